// File: rtl/fp_composer.sv
// -----------------------------------------------------------------------------
// fp_composer
//   Packs an unpacked floating-point result into an IEEE-754 binary64 word.
//   The input is a sign, an unbiased exponent and an extended mantissa, plus
//   flags that mark NaN, infinity and zero. The value of the mantissa is
//   in_mant * 2^(in_exp - 55).
//   The block normalizes the mantissa over several cycles, rounds it to
//   nearest-even, saturates to infinity on overflow and produces subnormal
//   results. It also raises the IEEE status flags. Only one operation is in
//   flight at a time.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   in_valid      operand valid            in_ready   high only while IDLE
//   in_sign       sign                     in_exp     13-bit signed exponent
//   in_mant       [56]=carry, [55]=leading one, [2:0]=guard/round/sticky
//   in_is_nan/inf/zero   special-value flags (priority nan > inf > zero)
//   out_valid     result valid             out_ready  consumer accepts
//   fp_out        packed binary64 result
//   overflow, underflow, inexact           status flags
//
// The exponent is held internally with one extra bit. A carry-out
// normalization at the top of the 13-bit range therefore cannot wrap, and it
// still reaches the overflow check.
// -----------------------------------------------------------------------------
module fp_composer #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [12:0] in_exp,
    input  logic [56:0] in_mant,
    input  logic        in_is_nan,
    input  logic        in_is_inf,
    input  logic        in_is_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] fp_out,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic signed [13:0] EXP_MIN      = -14'sd1022;
    localparam logic signed [13:0] EXP_COLLAPSE = -14'sd1079;
    localparam logic signed [13:0] STEP_E       = 14'(SHIFT_STEP);

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [13:0] exp_q, exp_d;
    logic [56:0]        mant_q, mant_d;
    logic [63:0]        fp_q, fp_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inx_q, inx_d;

    // Wide left-shift qualification
    logic signed [13:0] step_exp_s;
    logic               lshift_big_s;

    assign step_exp_s   = exp_q - STEP_E;
    assign lshift_big_s = (mant_q[55 -: SHIFT_STEP] == {SHIFT_STEP{1'b0}}) &&
                          (step_exp_s >= EXP_MIN);

    // Round-to-nearest-even datapath, used in ROUND
    logic               rnd_inc_s;
    logic [53:0]        rnd_sum_s;
    logic [52:0]        rnd_sig_s;
    logic signed [13:0] rnd_exp_s;
    logic signed [13:0] rnd_biased_s;
    logic               rnd_inx_s;
    logic               rnd_ovf_s;

    assign rnd_inc_s    = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    assign rnd_sum_s    = {1'b0, mant_q[55:3]} + {53'd0, rnd_inc_s};
    assign rnd_sig_s    = rnd_sum_s[53] ? rnd_sum_s[53:1] : rnd_sum_s[52:0];
    assign rnd_exp_s    = rnd_sum_s[53] ? (exp_q + 14'sd1) : exp_q;
    // A subnormal that rounds up into bit 52 has exp == -1022, so its biased
    // exponent becomes 1.
    assign rnd_biased_s = rnd_sig_s[52] ? (rnd_exp_s + 14'sd1023) : 14'sd0;
    assign rnd_inx_s    = |mant_q[2:0];
    assign rnd_ovf_s    = (rnd_biased_s >= 14'sd2047);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= 14'sd0;
            mant_q  <= 57'd0;
            fp_q    <= 64'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            fp_q    <= fp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        fp_d    = fp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    exp_d  = {in_exp[12], in_exp};
                    mant_d = in_mant;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    inx_d  = 1'b0;
                    if (in_is_nan) begin
                        fp_d    = 64'h7FF8_0000_0000_0000;
                        state_d = S_DONE;
                    end else if (in_is_inf) begin
                        fp_d    = {in_sign, 11'h7FF, 52'd0};
                        state_d = S_DONE;
                    end else if (in_is_zero) begin
                        fp_d    = {in_sign, 63'd0};
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NORM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NORM: begin
                if (mant_q == 57'd0) begin
                    fp_d    = {sign_q, 63'd0};
                    state_d = S_DONE;
                end else if (exp_q < EXP_COLLAPSE) begin
                    // Everything would be shifted into sticky anyway
                    mant_d = {56'd0, |mant_q};
                    exp_d  = EXP_MIN;
                end else if (mant_q[56] || (exp_q < EXP_MIN)) begin
                    // Right shift; bits falling off fold into sticky
                    mant_d = {1'b0, mant_q[56:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 14'sd1;
                end else if (mant_q[55] || (exp_q == EXP_MIN)) begin
                    state_d = S_ROUND;
                end else if (lshift_big_s) begin
                    mant_d = mant_q << SHIFT_STEP;
                    exp_d  = step_exp_s;
                end else begin
                    mant_d = {mant_q[55:0], 1'b0};
                    exp_d  = exp_q - 14'sd1;
                end
            end
            S_ROUND: begin
                if (rnd_ovf_s) begin
                    fp_d  = {sign_q, 11'h7FF, 52'd0};
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                    unf_d = 1'b0;
                end else begin
                    fp_d  = {sign_q, rnd_biased_s[10:0], rnd_sig_s[51:0]};
                    ovf_d = 1'b0;
                    inx_d = rnd_inx_s;
                    unf_d = rnd_inx_s & ~mant_q[55];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        fp_out    = fp_q;
        overflow  = ovf_q;
        underflow = unf_q;
        inexact   = inx_q;
    end

endmodule

// File: tb/tb_fp_composer.sv
module tb_fp_composer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [12:0] in_exp;
    logic [56:0] in_mant;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fp_out;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    typedef struct packed {
        logic [63:0] fp;
        logic        ovf;
        logic        unf;
        logic        inx;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    fp_composer #(.SHIFT_STEP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_is_zero (in_is_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fp_out     (fp_out),
        .overflow   (overflow),
        .underflow  (underflow),
        .inexact    (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    // Monitor: compares every completed output handshake against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h expected=none", fp_out);
            end else begin
                e = sb_q.pop_front();
                chk("fp_out", fp_out, e.fp);
                chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
                chk("underflow", {63'd0, underflow}, {63'd0, e.unf});
                chk("inexact", {63'd0, inexact}, {63'd0, e.inx});
            end
        end
    end

    // Issue one operation, push its expectation and check latency / busy
    task automatic send(input string nm, input logic s, input logic [12:0] e,
                        input logic [56:0] m, input logic nan, input logic inf,
                        input logic zero, input logic [63:0] efp, input logic eo,
                        input logic eu, input logic ei, input int lat);
        int  k;
        bit  busy_ok;
        exp_t x;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
            return;
        end
        in_valid   = 1'b1;
        in_sign    = s;
        in_exp     = e;
        in_mant    = m;
        in_is_nan  = nan;
        in_is_inf  = inf;
        in_is_zero = zero;
        x.fp = efp; x.ovf = eo; x.unf = eu; x.inx = ei;
        sb_q.push_back(x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 1;
        busy_ok = 1'b1;
        while (!out_valid && k < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        if (in_ready) busy_ok = 1'b0;
        chk({nm, "_latency"}, 64'(k), 64'(lat));
        chk({nm, "_in_ready_low"}, {63'd0, busy_ok}, 64'd1);
    endtask

    initial begin
        logic [56:0] m55, m56, frac1, m_ties;
        logic [63:0] one;
        m55    = 57'd1 << 55;
        m56    = 57'd1 << 56;
        frac1  = ((57'd1 << 52) - 57'd1) << 3;
        m_ties = m55 | frac1 | (57'd1 << 2);
        one    = 64'h3FF0_0000_0000_0000;
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 13'd0; in_mant = 57'd0;
        in_is_nan = 1'b0; in_is_inf = 1'b0; in_is_zero = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_fp_out", fp_out, 64'd0);
        chk("reset_flags", {61'd0, overflow, underflow, inexact}, 64'd0);

        send("one",     1'b0, 13'd0, m55, 1'b0, 1'b0, 1'b0, one, 1'b0, 1'b0, 1'b0, 3);
        send("carry",   1'b0, 13'd0, m56, 1'b0, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4);
        send("lshift",  1'b0, 13'd52, 57'd1 << 3, 1'b0, 1'b0, 1'b0, one, 1'b0, 1'b0, 1'b0, 16);
        send("tie_even",1'b0, 13'd0, m55 | (57'd1 << 2), 1'b0, 1'b0, 1'b0, one, 1'b0, 1'b0, 1'b1, 3);
        send("tie_odd", 1'b0, 13'd0, m55 | (57'd1 << 3) | (57'd1 << 2), 1'b0, 1'b0, 1'b0,
             64'h3FF0_0000_0000_0002, 1'b0, 1'b0, 1'b1, 3);
        send("rnd_carry", 1'b0, 13'd0, m_ties, 1'b0, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 3);
        send("overflow",1'b0, 13'd1024, m55, 1'b0, 1'b0, 1'b0, 64'h7FF0_0000_0000_0000, 1'b1, 1'b0, 1'b1, 3);
        send("sub_min", 1'b0, -13'sd1074, m55, 1'b0, 1'b0, 1'b0, 64'd1, 1'b0, 1'b0, 1'b0, 55);
        send("sub_half",1'b0, -13'sd1075, m55, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 56);
        send("sticky",  1'b0, -13'sd4000, m55, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 4);
        send("mant0",   1'b1, 13'd5, 57'd0, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 2);
        send("inf",     1'b1, 13'd0, m55, 1'b0, 1'b1, 1'b0, 64'hFFF0_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1);
        send("zero",    1'b1, 13'd0, m55, 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1);
        send("nan_prio",1'b1, 13'd0, m55, 1'b1, 1'b1, 1'b1, 64'h7FF8_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1);

        // Back-pressure: result must hold while out_ready is low
        @(posedge clk); #1;
        out_ready = 1'b0;
        send("nan_hold", 1'b0, 13'd0, 57'd0, 1'b1, 1'b0, 1'b0, 64'h7FF8_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_fp_out", fp_out, 64'h7FF8_0000_0000_0000);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_hs_out_valid", {63'd0, out_valid}, 64'd0);
        chk("after_hs_in_ready", {63'd0, in_ready}, 64'd1);
        send("after_hold", 1'b0, 13'd0, m55, 1'b0, 1'b0, 1'b0, one, 1'b0, 1'b0, 1'b0, 3);

        // Reset in the middle of a long normalization
        @(posedge clk); #1;
        while (!in_ready) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_sign = 1'b0; in_exp = -13'sd1074; in_mant = m55;
        in_is_nan = 1'b0; in_is_inf = 1'b0; in_is_zero = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("mid_norm_busy", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_fp_out", fp_out, 64'd0);
        send("post_reset", 1'b0, 13'd0, m55, 1'b0, 1'b0, 1'b0, one, 1'b0, 1'b0, 1'b0, 3);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_composer.md
Name: fp_composer

Overview:
- Inverse of the double-precision decomposer: takes an unpacked sign / unbiased exponent / extended mantissa plus special-value flags and produces a packed IEEE-754 binary64 word.
- Sits at the output of every arithmetic unit (add/mul/div).
- Normalizes iteratively (multi-cycle), applies round-to-nearest-even, handles overflow and subnormal results, and raises status flags.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
SHIFT_STEP, 4, maximum left-normalization shift per NORM cycle (1, 2, 4 or 8)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand valid
in_ready  output  1  block can accept (high only in IDLE)
in_sign  input  1  sign
in_exp  input  13  signed two's-complement unbiased exponent
in_mant  input  57  value = in_mant × 2^(in_exp−55); bit56 = carry, bit55 = leading one, [2:0] = guard/round/sticky
in_is_nan  input  1  result is NaN
in_is_inf  input  1  result is infinity
in_is_zero  input  1  result is zero
out_valid  output  1  fp_out valid
out_ready  input  1  consumer accepts
fp_out  output  64  packed binary64 result
overflow  output  1  result overflowed to infinity
underflow  output  1  result tiny and inexact
inexact  output  1  rounding lost bits

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-operation):
  - State goes to IDLE.
  - out_valid=0, fp_out=0, overflow/underflow/inexact=0.
  - in_ready=1 from the next cycle.
  - Any in-flight operation is abandoned.
- States: IDLE, NORM, ROUND, DONE.
- in_ready = (state==IDLE). No bypass: DONE→IDLE and a new accept never happen in the same cycle.
- IDLE, on in_valid:
  - Latch sign/exp/mant; clear flags.
  - If a special flag is set (priority nan > inf > zero), go to DONE with fp_out set as follows:
    - NaN: 0x7FF8000000000000 (canonical, sign 0).
    - Inf: {sign, 0x7FF, 52'b0}.
    - Zero: {sign, 63'b0}.
    - No flags raised.
  - Otherwise go to NORM.
- NORM, per cycle, first matching rule applies:
  1. mant==0 → DONE with signed zero, flags 0.
  2. exp < −1079 → mant = {56'b0, |mant}, exp = −1022; stay. This collapse is exact for sticky.
  3. mant[56]==1 or exp < −1022 → shift right 1, new bit0 = bit1|bit0 (sticky kept), exp+1; stay.
  4. mant[55]==1 or exp == −1022 → ROUND.
  5. Else shift left:
     - By SHIFT_STEP if mant[55:56−SHIFT_STEP] are all zero and exp−SHIFT_STEP ≥ −1022.
     - Otherwise by 1.
     - exp decremented by the shift amount; stay.
- ROUND (1 cycle):
  - G=mant[2], R=mant[1], S=mant[0], L=mant[3].
  - inc = G & (R|S|L); sig(54b) = mant[55:3] + inc.
  - If sig[53]: sig >>= 1, exp+1.
  - Biased exponent = sig[52] ? exp+1023 : 0. A subnormal that rounds up to 2^−1022 becomes biased 1.
  - inexact = G|R|S.
  - underflow = inexact & (mant[55]==0 before rounding).
  - If biased exponent ≥ 2047: fp_out = {sign, 0x7FF, 0}, overflow=1, inexact=1.
  - Else fp_out = {sign, biased[10:0], sig[51:0]}.
  - Go to DONE.
- DONE:
  - out_valid=1; fp_out and flags held stable while out_ready=0.
  - out_valid & out_ready → IDLE; out_valid drops next cycle.
- Latency (accept edge = cycle 0):
  - Specials and zero mantissa: out_valid at cycle 1 (zero mantissa via NORM: cycle 2).
  - Already-normalized operands: cycle 3.
  - Each extra shift adds 1 cycle.
  - Worst case bounded: ≤ 57 right shifts or ⌈55/SHIFT_STEP⌉+55 left shifts.
- Exponent arithmetic is 13-bit signed. Inputs outside [−4096, 4095] are impossible by width; overflow is detected before wrap because biased exponent is computed in 14 bits.

Test Plan:
- sign0, exp 0, mant 1<<55 → fp_out 0x3FF0000000000000, flags 0, out_valid exactly 3 cycles after accept, in_ready low cycles 1–3.
- exp 0, mant 1<<56 → 0x4000000000000000. exp 52, mant 1<<3 with SHIFT_STEP=4 → 0x3FF0000000000000 after left normalization.
- RNE, exp 0:
  - mant (1<<55)|(1<<2) → 0x3FF0000000000000, inexact=1.
  - mant (1<<55)|(1<<3)|(1<<2) → 0x3FF0000000000002.
  - mant (1<<55)|0xFFFFFF…F8 all-ones fraction plus G → 0x4000000000000000.
- Overflow: exp 1024, mant 1<<55 → 0x7FF0000000000000, overflow=1, inexact=1. Subnormal results:
  - exp −1074 → 0x0000000000000001, flags 0.
  - exp −1075 → 0x0000000000000000, underflow=1, inexact=1.
  - exp −4000 → 0, sticky path.
- in_is_nan with out_ready held 0 for 5 cycles → 0x7FF8000000000000 stable, out_valid held, in_ready 0. Then handshake → IDLE; next in_valid accepted one cycle later.
- Assert rst during NORM of the exp −1074 case → out_valid 0, in_ready 1 the next cycle; a following 1.0 request yields 0x3FF0000000000000.
